dht11_fnd_display: RTL and testbench

Downstream consumer of the DHT11 sensor reader. Takes its registered `humidity` and `temperature` bytes, converts each to decimal with a shared sequential double-dabble converter, and drives a 4-digit common-anode 7-segment display with time-multiplexed scanning. The display shows humidity tens/ones on the left two digits and temperature tens/ones on the right two.

---
 rtl/dht_disp_pkg.sv | 68 ++++++
 rtl/dht11_fnd_display_bin2bcd.sv | 57 +++++
 rtl/dht11_fnd_display.sv | 146 ++++++++++++++
 tb/tb_dht11_fnd_display.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/dht_disp_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : dht_disp_pkg
//  Description : Shared types and constants for the DHT11 7-segment display.
//  Revision    : 1.0 - initial release
// ============================================================================
package dht_disp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV_H = 2'd1,
        CONV_T = 2'd2
    } state_t;

    typedef logic [3:0] digit_t;

    localparam digit_t DIG_DASH = 4'hA;

    // Active-low segments {a,b,c,d,e,f,g,dp}; dp is always off
    localparam logic [7:0] SEG_0    = 8'b0000_0011;
    localparam logic [7:0] SEG_1    = 8'b1001_1111;
    localparam logic [7:0] SEG_2    = 8'b0010_0101;
    localparam logic [7:0] SEG_3    = 8'b0000_1101;
    localparam logic [7:0] SEG_4    = 8'b1001_1001;
    localparam logic [7:0] SEG_5    = 8'b0100_1001;
    localparam logic [7:0] SEG_6    = 8'b0100_0001;
    localparam logic [7:0] SEG_7    = 8'b0001_1111;
    localparam logic [7:0] SEG_8    = 8'b0000_0001;
    localparam logic [7:0] SEG_9    = 8'b0000_1001;
    localparam logic [7:0] SEG_DASH = 8'b1111_1101;

    // Digit enables, active-low; index 0 is the rightmost digit
    localparam logic [3:0] COM_0 = 4'b1110;
    localparam logic [3:0] COM_1 = 4'b1101;
    localparam logic [3:0] COM_2 = 4'b1011;
    localparam logic [3:0] COM_3 = 4'b0111;

    function automatic logic [7:0] seg_encode(input digit_t d);
        logic [7:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] com_decode(input logic [1:0] idx);
        logic [3:0] c;
        case (idx)
            2'd0:    c = COM_0;
            2'd1:    c = COM_1;
            2'd2:    c = COM_2;
            default: c = COM_3;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dht11_fnd_display_bin2bcd.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential 8-bit binary to 3-digit BCD (double dabble).
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        done,
    output logic [11:0] bcd
);

    // {hundreds, tens, ones, binary remainder}
    logic [19:0] r_shift;
    logic [2:0]  r_iter;
    logic        r_run;
    logic [19:0] w_adj;
    logic [19:0] w_next;

    always_comb begin
        w_adj = r_shift;
        if (w_adj[11:8]  >= 4'd5) w_adj[11:8]  = w_adj[11:8]  + 4'd3;
        if (w_adj[15:12] >= 4'd5) w_adj[15:12] = w_adj[15:12] + 4'd3;
        if (w_adj[19:16] >= 4'd5) w_adj[19:16] = w_adj[19:16] + 4'd3;
        w_next = {w_adj[18:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_shift <= 20'd0;
            r_iter  <= 3'd0;
            r_run   <= 1'b0;
            done    <= 1'b0;
            bcd     <= 12'd0;
        end else begin
            done <= 1'b0;
            if (r_run) begin
                r_shift <= w_next;
                r_iter  <= r_iter + 3'd1;
                if (r_iter == 3'd7) begin
                    r_run <= 1'b0;
                    done  <= 1'b1;
                    bcd   <= w_next[19:8];
                end
            end else if (start) begin
                r_shift <= {12'd0, bin};
                r_iter  <= 3'd0;
                r_run   <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dht11_fnd_display.sv
`default_nettype none
// ============================================================================
//  Module      : dht11_fnd_display
//  Description : Converts DHT11 humidity/temperature to decimal and scans a
//                4-digit common-anode 7-segment display.
//  Revision    : 1.0 - initial release
// ============================================================================
module dht11_fnd_display
    import dht_disp_pkg::*;
#(
    parameter int SCAN_CYCLES = 125000
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic [7:0] humidity,
    input  logic [7:0] temperature,
    output logic [3:0] com,
    output logic [7:0] seg_7,
    output logic       busy
);

    localparam int CNT_W = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(SCAN_CYCLES - 1);

    state_t       r_state;
    state_t       w_state_next;
    logic [7:0]   r_snap_h;
    logic [7:0]   r_snap_t;
    digit_t       r_h10, r_h1, r_t10, r_t1;
    digit_t       r_hold_h10, r_hold_h1;
    logic [CNT_W-1:0] r_scan_cnt;
    logic [1:0]   r_digit_idx;

    logic         w_start;
    logic [7:0]   w_bin;
    logic         w_done;
    logic [11:0]  w_bcd;
    logic         w_changed;
    logic         w_over;
    digit_t       w_tens, w_ones;
    digit_t       w_sel;

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .reset_p (reset_p),
        .start   (w_start),
        .bin     (w_bin),
        .done    (w_done),
        .bcd     (w_bcd)
    );

    assign w_changed = (humidity != r_snap_h) || (temperature != r_snap_t);

    // Values above 99 cannot be shown in two digits, so both become dashes
    assign w_over = (w_bcd[11:8] != 4'd0);
    assign w_tens = w_over ? DIG_DASH : w_bcd[7:4];
    assign w_ones = w_over ? DIG_DASH : w_bcd[3:0];

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_bin        = r_snap_t;
        case (r_state)
            IDLE: begin
                if (w_changed) begin
                    w_start      = 1'b1;
                    w_bin        = humidity;
                    w_state_next = CONV_H;
                end
            end
            CONV_H: begin
                if (w_done) begin
                    w_start      = 1'b1;
                    w_bin        = r_snap_t;
                    w_state_next = CONV_T;
                end
            end
            CONV_T: begin
                if (w_done) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_state    <= IDLE;
            r_snap_h   <= 8'd0;
            r_snap_t   <= 8'd0;
            r_hold_h10 <= 4'd0;
            r_hold_h1  <= 4'd0;
            r_h10      <= 4'd0;
            r_h1       <= 4'd0;
            r_t10      <= 4'd0;
            r_t1       <= 4'd0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && w_changed) begin
                r_snap_h <= humidity;
                r_snap_t <= temperature;
            end
            if (r_state == CONV_H && w_done) begin
                r_hold_h10 <= w_tens;
                r_hold_h1  <= w_ones;
            end
            // All four digits update together so a reading is never torn
            if (r_state == CONV_T && w_done) begin
                r_h10 <= r_hold_h10;
                r_h1  <= r_hold_h1;
                r_t10 <= w_tens;
                r_t1  <= w_ones;
            end
        end
    end

    assign busy = (r_state != IDLE);

    always_comb begin
        case (r_digit_idx)
            2'd0:    w_sel = r_t1;
            2'd1:    w_sel = r_t10;
            2'd2:    w_sel = r_h1;
            default: w_sel = r_h10;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= 2'd0;
            com         <= COM_0;
            seg_7       <= SEG_0;
        end else begin
            if (r_scan_cnt == c_cnt_last) begin
                r_scan_cnt  <= '0;
                r_digit_idx <= r_digit_idx + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            com   <= com_decode(r_digit_idx);
            seg_7 <= seg_encode(w_sel);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dht11_fnd_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dht11_fnd_display
//  Description : Scoreboard bench for dht11_fnd_display with SCAN_CYCLES=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dht11_fnd_display;

    logic       clk;
    logic       reset_p;
    logic [7:0] humidity;
    logic [7:0] temperature;
    logic [3:0] com;
    logic [7:0] seg_7;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] h10;
        logic [7:0] h1;
        logic [7:0] t10;
        logic [7:0] t1;
        int         busy_len;
    } exp_t;

    exp_t q[$];

    dht11_fnd_display #(.SCAN_CYCLES(4)) dut (
        .clk         (clk),
        .reset_p     (reset_p),
        .humidity    (humidity),
        .temperature (temperature),
        .com         (com),
        .seg_7       (seg_7),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_seg(input exp_t e, input logic [3:0] c);
        case (c)
            4'b1110: return e.t1;
            4'b1101: return e.t10;
            4'b1011: return e.h1;
            4'b0111: return e.h10;
            default: return 8'h00;
        endcase
    endfunction

    task automatic push(input logic [7:0] h10, input logic [7:0] h1,
                        input logic [7:0] t10, input logic [7:0] t1, input int len);
        exp_t e;
        e.h10 = h10; e.h1 = h1; e.t10 = t10; e.t1 = t1; e.busy_len = len;
        q.push_back(e);
    endtask

    // Monitor: each busy fall completes a transaction; check its length and
    // the scanned display for the following 17 cycles.
    initial begin : monitor
        int   hi_cnt;
        logic prev_busy;
        exp_t e;
        hi_cnt    = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busy) begin
                hi_cnt++;
            end else if (prev_busy) begin
                if (q.size() == 0) begin
                    chk("unexpected_conversion", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("busy_len", hi_cnt, e.busy_len);
                    hi_cnt = 0;
                    for (int k = 0; k < 17; k++) begin
                        @(negedge clk);
                        if (busy) hi_cnt++;
                        chk("com_onehot", {31'd0, com inside {4'b1110, 4'b1101, 4'b1011, 4'b0111}}, 32'd1);
                        chk("scan_seg", {20'd0, com, seg_7}, {20'd0, com, exp_seg(e, com)});
                    end
                end
                hi_cnt = busy ? hi_cnt : 0;
            end
            prev_busy = busy;
        end
    end

    initial begin : stimulus
        exp_t last;
        int   busy_seen;
        reset_p     = 1'b1;
        humidity    = 8'd0;
        temperature = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_p = 1'b0;

        // Reset state and idle scan walk
        chk("reset_com", {28'd0, com}, 32'h0000000E);
        chk("reset_seg", {24'd0, seg_7}, 32'h00000003);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge clk);
        chk("scan_com1", {28'd0, com}, 32'h0000000D);
        repeat (4) @(negedge clk);
        chk("scan_com2", {28'd0, com}, 32'h0000000B);
        repeat (4) @(negedge clk);
        chk("scan_com3", {28'd0, com}, 32'h00000007);
        chk("scan_seg_zero", {24'd0, seg_7}, 32'h00000003);
        repeat (4) @(negedge clk);
        chk("scan_com0", {28'd0, com}, 32'h0000000E);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // 80 / 25
        push(8'b00000001, 8'b00000011, 8'b00100101, 8'b01001001, 18);
        humidity = 8'd80; temperature = 8'd25;
        repeat (60) @(negedge clk);

        // 150 / 7: humidity out of range
        push(8'b11111101, 8'b11111101, 8'b00000011, 8'b00011111, 18);
        humidity = 8'd150; temperature = 8'd7;
        repeat (60) @(negedge clk);

        // 100 / 99 boundaries
        push(8'b11111101, 8'b11111101, 8'b00001001, 8'b00001001, 18);
        humidity = 8'd100; temperature = 8'd99;
        repeat (60) @(negedge clk);

        // Temperature changes mid-conversion
        push(8'b00000001, 8'b00000011, 8'b00100101, 8'b01001001, 18);
        push(8'b00000001, 8'b00000011, 8'b00100101, 8'b01000001, 18);
        humidity = 8'd80; temperature = 8'd25;
        repeat (5) @(negedge clk);
        temperature = 8'd26;
        repeat (70) @(negedge clk);

        // Reset at cycle 10 of a conversion, then restart with current inputs
        push(8'b00000011, 8'b00000011, 8'b00000011, 8'b00000011, 10);
        push(8'b00001101, 8'b00001101, 8'b10011001, 8'b10011001, 18);
        humidity = 8'd33; temperature = 8'd44;
        repeat (10) @(negedge clk);
        reset_p = 1'b1;
        @(negedge clk);
        reset_p = 1'b0;
        chk("reset_mid_busy", {31'd0, busy}, 32'd0);
        chk("reset_mid_com", {28'd0, com}, 32'h0000000E);
        chk("reset_mid_seg", {24'd0, seg_7}, 32'h00000003);
        repeat (60) @(negedge clk);

        // Constant inputs: no conversion and a stable display
        last.h10 = 8'b00001101; last.h1 = 8'b00001101;
        last.t10 = 8'b10011001; last.t1 = 8'b10011001; last.busy_len = 0;
        busy_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (busy) busy_seen++;
            chk("hold_seg", {20'd0, com, seg_7}, {20'd0, com, exp_seg(last, com)});
        end
        chk("hold_busy_cycles", busy_seen, 32'd0);
        chk("queue_empty", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
